decimal_entry_to_binary: RTL and testbench

// Keypad-side encoder for the fixed-point calculator; the inverse of the

---
 rtl/decimal_entry_to_binary_if.sv | 25 ++
 rtl/decimal_entry_to_binary.sv | 167 ++++++++++++++++
 tb/tb_decimal_entry_to_binary.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decimal_entry_to_binary_if.sv
// Keypad entry bus: keypress strobes in, converted Q-format value out.
interface decimal_entry_to_binary_if #(
  parameter int W = 16
);
  logic         digit_valid;
  logic [3:0]   digit_in;
  logic         dot_in;
  logic         sign_in;
  logic         clear_in;
  logic         enter_in;
  logic [W-1:0] value_out;
  logic         value_valid;
  logic         busy;
  logic         error;

  modport master (
    output digit_valid, digit_in, dot_in, sign_in, clear_in, enter_in,
    input  value_out, value_valid, busy, error
  );

  modport slave (
    input  digit_valid, digit_in, dot_in, sign_in, clear_in, enter_in,
    output value_out, value_valid, busy, error
  );
endinterface

// File: rtl/decimal_entry_to_binary.sv
// Keypad decimal entry to sign-magnitude fixed-point encoder.
//
// state  | meaning
// S_INT  | collecting integer digits
// S_FRAC | collecting up to two fraction digits (tenths, hundredths)
// S_CONV | serial restoring divide, one quotient bit per cycle
// S_DONE | one-cycle result strobe, then entry state is cleared
module decimal_entry_to_binary #(
  parameter int INT_BITS  = 9,
  parameter int FRAC_BITS = 6
) (
  input logic clk,
  input logic rst,
  decimal_entry_to_binary_if.slave bus
);

  localparam int W       = 1 + INT_BITS + FRAC_BITS;
  localparam int QB      = FRAC_BITS + 1;
  localparam int DIV_W   = FRAC_BITS + 7;
  localparam int NXT_W   = INT_BITS + 4;
  localparam int CNT_W   = $clog2(QB + 1);
  localparam int MAX_INT = (1 << INT_BITS) - 1;

  typedef enum logic [1:0] {S_INT, S_FRAC, S_CONV, S_DONE} state_t;

  state_t                state;
  logic [INT_BITS-1:0]   int_acc;
  logic [6:0]            frac_acc;
  logic [1:0]            frac_cnt;
  logic                  sign_r;
  logic                  fresh;
  logic [6:0]            rem;
  logic [QB-1:0]         dsh;
  logic [QB-1:0]         quo;
  logic [CNT_W-1:0]      cnt;
  logic [W-1:0]          value_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  error_r;

  logic [NXT_W-1:0]      nxt_int;
  logic                  digit_ok;
  logic                  int_fits;
  logic [DIV_W-1:0]      dividend;
  logic [7:0]            trial;
  logic                  trial_ge;
  logic [QB-1:0]         quo_nxt;
  logic [FRAC_BITS-1:0]  frac_bin;
  logic                  sign_out;
  logic                  accept;

  assign bus.value_out   = value_r;
  assign bus.value_valid = valid_r;
  assign bus.busy        = busy_r;
  assign bus.error       = error_r;

  // Datapath helpers: next integer, divider step, result packing, event acceptance.
  always_comb begin
    nxt_int  = NXT_W'(int_acc) * NXT_W'(10) + NXT_W'(bus.digit_in);
    digit_ok = (bus.digit_in <= 4'd9);
    int_fits = (nxt_int <= NXT_W'(MAX_INT));
    // frac*64 + 99 so that the floor division yields ceil(frac*64/100)
    dividend = DIV_W'(frac_acc) * DIV_W'(1 << FRAC_BITS) + DIV_W'(99);
    trial    = {rem, dsh[QB-1]};
    trial_ge = (trial >= 8'd100);
    quo_nxt  = {quo[QB-2:0], trial_ge};
    // quotient can reach 2**FRAC_BITS for .99; clamp to the largest fraction
    frac_bin = quo_nxt[QB-1] ? '1 : quo_nxt[FRAC_BITS-1:0];
    sign_out = sign_r && ((int_acc != '0) || (frac_bin != '0));
    accept   = 1'b0;
    if (state == S_INT || state == S_FRAC) begin
      if (bus.clear_in)        accept = 1'b0;
      else if (bus.enter_in)   accept = 1'b1;
      else if (bus.dot_in)     accept = (state == S_INT);
      else if (bus.digit_valid) begin
        if (digit_ok)
          accept = (state == S_INT) ? int_fits : (frac_cnt != 2'd2);
      end
      else if (bus.sign_in)    accept = 1'b1;
    end
  end

  // Entry FSM, serial divider and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INT;
      int_acc  <= '0;
      frac_acc <= '0;
      frac_cnt <= '0;
      sign_r   <= 1'b0;
      fresh    <= 1'b0;
      rem      <= '0;
      dsh      <= '0;
      quo      <= '0;
      cnt      <= '0;
      value_r  <= '0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      case (state)
        S_INT, S_FRAC: begin
          // a stale error from the previous entry lasts until this entry does something
          if (accept && fresh) begin
            error_r <= 1'b0;
            fresh   <= 1'b0;
          end
          if (bus.clear_in) begin
            state    <= S_INT;
            int_acc  <= '0;
            frac_acc <= '0;
            frac_cnt <= '0;
            sign_r   <= 1'b0;
            error_r  <= 1'b0;
            fresh    <= 1'b0;
          end else if (bus.enter_in) begin
            state  <= S_CONV;
            busy_r <= 1'b1;
            rem    <= 7'(dividend[DIV_W-1:QB]);
            dsh    <= dividend[QB-1:0];
            quo    <= '0;
            cnt    <= CNT_W'(QB - 1);
          end else if (bus.dot_in) begin
            if (state == S_INT) state <= S_FRAC;
          end else if (bus.digit_valid) begin
            if (digit_ok) begin
              if (state == S_INT) begin
                if (int_fits) int_acc <= INT_BITS'(nxt_int);
                else          error_r <= 1'b1;
              end else if (frac_cnt != 2'd2) begin
                frac_acc <= (frac_cnt == 2'd0) ? 7'(bus.digit_in) * 7'd10
                                               : frac_acc + 7'(bus.digit_in);
                frac_cnt <= frac_cnt + 2'd1;
              end
            end
          end else if (bus.sign_in) begin
            sign_r <= ~sign_r;
          end
        end
        S_CONV: begin
          rem <= trial_ge ? 7'(trial - 8'd100) : trial[6:0];
          dsh <= {dsh[QB-2:0], 1'b0};
          quo <= quo_nxt;
          if (cnt == '0) begin
            state   <= S_DONE;
            value_r <= {sign_out, int_acc, frac_bin};
            valid_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_INT;
          valid_r  <= 1'b0;
          busy_r   <= 1'b0;
          int_acc  <= '0;
          frac_acc <= '0;
          frac_cnt <= '0;
          sign_r   <= 1'b0;
          fresh    <= 1'b1;
        end
        default: state <= S_INT;
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// Bench for the keypad decimal encoder: directed keypad scenarios plus random
// keypresses, all checked against a decimal-arithmetic reference model.
module tb_decimal_entry_to_binary;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decimal_entry_to_binary_if bus ();

  decimal_entry_to_binary dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model of the keypad entry
  int          m_int, m_frac, m_fcnt;
  bit          m_in_frac, m_sign, m_err, m_fresh;
  logic [15:0] m_value, m_out;
  logic [15:0] last_value;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.dot_in      = 1'b0;
    bus.sign_in     = 1'b0;
    bus.clear_in    = 1'b0;
    bus.enter_in    = 1'b0;
  endtask

  task automatic model_clear_entry();
    m_int = 0; m_frac = 0; m_fcnt = 0; m_in_frac = 0; m_sign = 0;
  endtask

  task automatic model_accept();
    if (m_fresh) begin
      m_err   = 0;
      m_fresh = 0;
    end
  endtask

  task automatic model_step(input bit dv, input int d, input bit dot, input bit sgn,
                            input bit clr, input bit ent, output bit conv);
    int fb;
    bit s;
    conv = 0;
    if (clr) begin
      model_clear_entry();
      m_err = 0; m_fresh = 0;
    end else if (ent) begin
      model_accept();
      fb = (m_frac * 64 + 99) / 100;
      if (fb > 63) fb = 63;
      s = m_sign && (m_int != 0 || fb != 0);
      m_value = 16'((int'(s) << 15) | (m_int << 6) | fb);
      conv = 1;
    end else if (dot) begin
      if (!m_in_frac) begin
        m_in_frac = 1;
        model_accept();
      end
    end else if (dv) begin
      if (d <= 9) begin
        if (!m_in_frac) begin
          if (m_int * 10 + d <= 511) begin
            m_int = m_int * 10 + d;
            model_accept();
          end else begin
            m_err = 1;
          end
        end else if (m_fcnt < 2) begin
          if (m_fcnt == 0) m_frac = 10 * d;
          else             m_frac = m_frac + d;
          m_fcnt++;
          model_accept();
        end
      end
    end else if (sgn) begin
      m_sign = !m_sign;
      model_accept();
    end
  endtask

  // Follow a conversion from cycle E+1 to E+9, hammering keys while busy.
  task automatic run_conv();
    for (int k = 1; k <= 8; k++) begin
      check("conv_busy", bus.busy, 1);
      check("conv_valid", bus.value_valid, (k == 8));
      check("conv_error", bus.error, m_err);
      if (k == 8) begin
        check("conv_value", bus.value_out, m_value);
        last_value = bus.value_out;
        m_out = m_value;
        idle_inputs();
      end else begin
        check("conv_hold", bus.value_out, m_out);
        bus.digit_valid = 1'($urandom);
        bus.digit_in    = 4'($urandom);
        bus.dot_in      = 1'($urandom);
        bus.sign_in     = 1'($urandom);
        bus.clear_in    = 1'($urandom);
        bus.enter_in    = 1'($urandom);
      end
      @(negedge clk);
    end
    model_clear_entry();
    m_fresh = 1;
    check("after_busy", bus.busy, 0);
    check("after_valid", bus.value_valid, 0);
  endtask

  task automatic press(input bit dv, input int d, input bit dot, input bit sgn,
                       input bit clr, input bit ent);
    bit conv;
    bus.digit_valid = dv;
    bus.digit_in    = 4'(d);
    bus.dot_in      = dot;
    bus.sign_in     = sgn;
    bus.clear_in    = clr;
    bus.enter_in    = ent;
    model_step(dv, d, dot, sgn, clr, ent, conv);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    if (conv) begin
      run_conv();
    end else begin
      check("idle_busy", bus.busy, 0);
      check("idle_valid", bus.value_valid, 0);
      check("idle_error", bus.error, m_err);
      check("idle_hold", bus.value_out, m_out);
    end
  endtask

  task automatic key(input int d);
    press(1, d, 0, 0, 0, 0);
  endtask
  task automatic dot();   press(0, 0, 1, 0, 0, 0); endtask
  task automatic sign();  press(0, 0, 0, 1, 0, 0); endtask
  task automatic clear(); press(0, 0, 0, 0, 1, 0); endtask
  task automatic enter(); press(0, 0, 0, 0, 0, 1); endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear_entry();
    m_err = 0; m_fresh = 0; m_out = 16'h0000;
  endtask

  initial begin
    idle_inputs();
    reset_dut();
    check("rst_value", bus.value_out, 16'h0000);
    check("rst_valid", bus.value_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_error", bus.error, 0);

    // 12.50
    key(1); key(2); dot(); key(5); enter();
    check("v12_50", last_value, 16'h0320);

    // -3.01
    sign(); key(3); dot(); key(0); key(1); enter();
    check("vm3_01", last_value, 16'h80C1);

    // integer overflow sets sticky error
    key(5); key(1); key(2);
    check("ovf_error", bus.error, 1);
    enter();
    check("v51", last_value, 16'h0CC0);
    check("err_sticky", bus.error, 1);
    key(3);
    check("err_cleared", bus.error, 0);
    clear();

    // third fraction digit ignored, saturation, no negative zero
    dot(); key(9); key(9); key(7); enter();
    check("v_sat", last_value, 16'h003F);
    sign(); enter();
    check("v_negzero", last_value, 16'h0000);

    // enter beats a simultaneous digit
    key(8); press(1, 7, 0, 0, 0, 1);
    check("v_enter_prio", last_value, 16'h0200);

    // clear mid-fraction holds the output
    key(6); dot(); key(5); clear();
    check("clear_hold", bus.value_out, 16'h0200);
    key(4); enter();
    check("v4", last_value, 16'h0100);

    // reset during a conversion drops it
    key(7); enter();
    check("v7", last_value, 16'h01C0);
    key(3);
    bus.enter_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.value_valid, 0);
    check("mid_rst_value", bus.value_out, 16'h0000);
    rst = 1'b0;
    model_clear_entry();
    m_err = 0; m_fresh = 0; m_out = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mid_rst_nopulse", bus.value_valid, 0);
    end

    // random keypresses, including simultaneous ones
    for (int i = 0; i < 400; i++) begin
      press($urandom_range(0, 99) < 55,
            $urandom_range(0, 11),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 11) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
